cr_clint_tcipif_arb: RTL
========================

CR_CLINT_TCIPIF_ARB -- requirements
Module: cr_clint_tcipif_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: CLINT register address width.
REQ-002 SHALL have parameter TMO_CYC, default 15 (range 1..255): cycles in XFER without completion before abort.
REQ-003 SHALL have port forever_cpuclk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port cpurst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have ports core_clint_req / dbg_clint_req, input, 1 each: requester holds transfer until granted.
REQ-006 SHALL have ports core_clint_addr / dbg_clint_addr, input, ADDR_W each: transfer address.
REQ-007 SHALL have ports core_clint_write / dbg_clint_write, input, 1 each: 1=write, 0=read.
REQ-008 SHALL have ports core_clint_wdata / dbg_clint_wdata, input, 32 each: write data.
REQ-009 SHALL have ports core_clint_gnt / dbg_clint_gnt, output, 1 each: request accepted this cycle.
REQ-010 SHALL have ports core_clint_cmplt / dbg_clint_cmplt, output, 1 each: transfer done, 1-cycle pulse.
REQ-011 SHALL have ports core_clint_rdata / dbg_clint_rdata, output, 32 each: read data, valid with cmplt.
REQ-012 SHALL have ports core_clint_err / dbg_clint_err, output, 1 each: timeout abort, valid with cmplt.
REQ-013 SHALL have ports tcipif_clint_sel (1), tcipif_clint_addr (ADDR_W), tcipif_clint_write (1), tcipif_clint_wdata (32), all outputs: shared CLINT bus.
REQ-014 SHALL have ports clint_tcipif_cmplt (1) and clint_tcipif_rdata (32), inputs: CLINT response.

Function
REQ-015 SHALL implement states IDLE, XFER, RESP; one transfer outstanding.
REQ-016 IDLE: any req -> pick winner, pulse winner gnt same cycle, latch addr/write/wdata/owner, go XFER.
REQ-017 Simultaneous core+dbg req SHALL grant per REQ-029/030; loser gnt stays 0, request remains pending.
REQ-018 XFER: tcipif_clint_sel=1, addr/write/wdata from latched registers only (requester inputs ignored).
REQ-019 XFER with clint_tcipif_cmplt=1: capture rdata (0 for writes), err=0, go RESP.
REQ-020 XFER timeout counter SHALL start at 0 on entry, increment per cycle without cmplt; at TMO_CYC: drop sel, rdata=0, err=1, go RESP.
REQ-021 cmplt arriving in the same cycle as timeout SHALL win (normal completion, err=0).
REQ-022 RESP: owner cmplt=1 for exactly one cycle with registered rdata/err; other requester outputs 0; go IDLE.
REQ-023 No gnt in XFER or RESP; latency req(N, IDLE) -> sel N+1 -> cmplt N+2 with zero-wait CLINT; max throughput 1 transfer per 3 cycles.
REQ-024 tcipif_clint_sel SHALL be 0 in IDLE and RESP; addr/wdata outputs hold last latched value there.
REQ-025 rdata/err outputs SHALL be 0 whenever respective cmplt is 0.

Reset
REQ-026 cpurst=1 SHALL force IDLE, all gnt/cmplt/err/sel=0, rdata=0, latched fields=0, timeout counter=0, RR pointer=dbg.
REQ-027 Reset mid-XFER/RESP SHALL drop the transfer with no cmplt to either requester.
REQ-028 First cycle after reset release SHALL be IDLE, able to grant.

Configuration
REQ-029 With CR_CLINT_ARB_RR_EN defined: round-robin; pointer = last granted owner; tie goes to the other requester; pointer updates only on gnt.
REQ-030 Without CR_CLINT_ARB_RR_EN: fixed priority, core always wins ties; no pointer register.

Structure
REQ-031 Shared package cr_clint_pkg SHALL hold state encoding (IDLE/XFER/RESP), owner encoding (CORE=0, DBG=1), CLINT address constants (MSIP 0x0000, MTIMECMPLO 0x4000, MTIMECMPHI 0x4004, MTIMELO 0xbff8, MTIMEHI 0xbffc).
REQ-032 Sub-module cr_clint_arb_pick SHALL contain the 2-way winner selection (RR or fixed, per macro); FSM, timeout counter, data registers stay in top.

Verification
REQ-033 Core read 0x4000, CLINT cmplt same cycle, rdata 0x1234_5678 -> core_gnt N, sel N+1 addr 0x4000, core_cmplt N+2 rdata 0x1234_5678 err 0.
REQ-034 Core and dbg req together, RR enabled, after reset -> core granted first, dbg next IDLE; repeat tie -> core again (alternation); RR disabled -> core both times.
REQ-035 Dbg write 0x0000 wdata 0x1, CLINT never cmplt, TMO_CYC=15 -> sel high 15 cycles, then dbg_cmplt with err=1 rdata 0.
REQ-036 cmplt on exactly cycle TMO_CYC of XFER -> err=0, rdata from CLINT.
REQ-037 Assert cpurst during XFER -> next cycle IDLE, sel=0, no cmplt pulse; pending req then granted normally.
REQ-038 Requester changes addr/wdata during XFER -> CLINT bus keeps latched values unchanged.

Source files
------------

// File: rtl/cr_clint_pkg.sv
// Shared CLINT arbiter definitions: FSM state and owner encodings, data/timeout
// widths and the CLINT register address map.
package cr_clint_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned TMO_W    = 8;
    localparam int unsigned CLINT_AW = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWNER_CORE = 1'b0,
        OWNER_DBG  = 1'b1
    } owner_e;

    localparam logic [CLINT_AW-1:0] CLINT_MSIP       = 16'h0000;
    localparam logic [CLINT_AW-1:0] CLINT_MTIMECMPLO = 16'h4000;
    localparam logic [CLINT_AW-1:0] CLINT_MTIMECMPHI = 16'h4004;
    localparam logic [CLINT_AW-1:0] CLINT_MTIMELO    = 16'hbff8;
    localparam logic [CLINT_AW-1:0] CLINT_MTIMEHI    = 16'hbffc;

endpackage

// File: rtl/cr_clint_arb_pick.sv
// Two-way winner selection between core and debug requesters.
// CR_CLINT_ARB_RR_EN selects round-robin (pointer = last granted); otherwise core has fixed priority.
module cr_clint_arb_pick
    import cr_clint_pkg::*;
(
`ifdef CR_CLINT_ARB_RR_EN
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   upd_i,
`endif
    input  logic   core_req_i,
    input  logic   dbg_req_i,
    output logic   win_vld_c_o,
    output owner_e win_owner_c_o
);

    assign win_vld_c_o = core_req_i | dbg_req_i;

`ifdef CR_CLINT_ARB_RR_EN
    owner_e ptr_q;

    // Pointer remembers the last granted owner; reset value makes core win the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= OWNER_DBG;
        end else if (upd_i) begin
            ptr_q <= win_owner_c_o;
        end
    end

    always_comb begin
        win_owner_c_o = OWNER_CORE;
        if (core_req_i && dbg_req_i) begin
            win_owner_c_o = (ptr_q == OWNER_CORE) ? OWNER_DBG : OWNER_CORE;
        end else if (dbg_req_i) begin
            win_owner_c_o = OWNER_DBG;
        end
    end
`else
    always_comb begin
        win_owner_c_o = OWNER_CORE;
        if (dbg_req_i && !core_req_i) begin
            win_owner_c_o = OWNER_DBG;
        end
    end
`endif

endmodule

// File: rtl/cr_clint_tcipif_arb.sv
// Arbitrates core and debug CLINT requests onto the shared TCIPIF bus, one transfer outstanding,
// with a per-transfer timeout. Define CR_CLINT_ARB_RR_EN for round-robin instead of core priority.
module cr_clint_tcipif_arb
    import cr_clint_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned TMO_CYC = 15
) (
    input  logic              forever_cpuclk,
    input  logic              cpurst,

    input  logic              core_clint_req,
    input  logic [ADDR_W-1:0] core_clint_addr,
    input  logic              core_clint_write,
    input  logic [DATA_W-1:0] core_clint_wdata,
    output logic              core_clint_gnt,
    output logic              core_clint_cmplt,
    output logic [DATA_W-1:0] core_clint_rdata,
    output logic              core_clint_err,

    input  logic              dbg_clint_req,
    input  logic [ADDR_W-1:0] dbg_clint_addr,
    input  logic              dbg_clint_write,
    input  logic [DATA_W-1:0] dbg_clint_wdata,
    output logic              dbg_clint_gnt,
    output logic              dbg_clint_cmplt,
    output logic [DATA_W-1:0] dbg_clint_rdata,
    output logic              dbg_clint_err,

    output logic              tcipif_clint_sel,
    output logic [ADDR_W-1:0] tcipif_clint_addr,
    output logic              tcipif_clint_write,
    output logic [DATA_W-1:0] tcipif_clint_wdata,
    input  logic              clint_tcipif_cmplt,
    input  logic [DATA_W-1:0] clint_tcipif_rdata
);

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic                write_q, write_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q,   err_d;
    logic [TMO_W-1:0]    tmo_q,   tmo_d;

    logic                win_vld_c;
    owner_e              win_owner_c;

    cr_clint_arb_pick u_pick (
`ifdef CR_CLINT_ARB_RR_EN
        .clk_i         (forever_cpuclk),
        .rst_i         (cpurst),
        .upd_i         (core_clint_gnt | dbg_clint_gnt),
`endif
        .core_req_i    (core_clint_req),
        .dbg_req_i     (dbg_clint_req),
        .win_vld_c_o   (win_vld_c),
        .win_owner_c_o (win_owner_c)
    );

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_q <= ST_IDLE;
            owner_q <= OWNER_CORE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    // Grants are suppressed while reset is held so no transfer starts in a reset cycle.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        addr_d         = addr_q;
        write_d        = write_q;
        wdata_d        = wdata_q;
        rdata_d        = rdata_q;
        err_d          = err_q;
        tmo_d          = tmo_q;
        core_clint_gnt = 1'b0;
        dbg_clint_gnt  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (win_vld_c && !cpurst) begin
                    owner_d = win_owner_c;
                    tmo_d   = '0;
                    state_d = ST_XFER;
                    if (win_owner_c == OWNER_DBG) begin
                        dbg_clint_gnt = 1'b1;
                        addr_d        = dbg_clint_addr;
                        write_d       = dbg_clint_write;
                        wdata_d       = dbg_clint_wdata;
                    end else begin
                        core_clint_gnt = 1'b1;
                        addr_d         = core_clint_addr;
                        write_d        = core_clint_write;
                        wdata_d        = core_clint_wdata;
                    end
                end
            end
            ST_XFER: begin
                // Completion has priority over a timeout landing in the same cycle.
                if (clint_tcipif_cmplt) begin
                    rdata_d = write_q ? '0 : clint_tcipif_rdata;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign tcipif_clint_sel   = (state_q == ST_XFER);
    assign tcipif_clint_addr  = addr_q;
    assign tcipif_clint_write = write_q;
    assign tcipif_clint_wdata = wdata_q;

    assign core_clint_cmplt = (state_q == ST_RESP) && (owner_q == OWNER_CORE);
    assign dbg_clint_cmplt  = (state_q == ST_RESP) && (owner_q == OWNER_DBG);
    assign core_clint_rdata = core_clint_cmplt ? rdata_q : '0;
    assign dbg_clint_rdata  = dbg_clint_cmplt  ? rdata_q : '0;
    assign core_clint_err   = core_clint_cmplt & err_q;
    assign dbg_clint_err    = dbg_clint_cmplt  & err_q;

endmodule
